// File: rtl/cordic_pkg.sv
// Shared constants, table generators and FSM encoding for the CORDIC trig blocks.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam real K_GAIN = 0.6072529350;
    localparam real PI_R   = 3.14159265358979323846;

    // atan(2^-i) in binary angle units where 2^frac_bits represents pi.
    function automatic int atan_bam(input int i, input int frac_bits);
        real t;
        real scale;
        t = 1.0;
        for (int j = 0; j < i; j++) t = t / 2.0;
        scale = 1.0;
        for (int j = 0; j < frac_bits; j++) scale = scale * 2.0;
        return int'($atan(t) / PI_R * scale);
    endfunction

    // CORDIC gain compensation K scaled so that 2^frac_bits represents 1.0.
    function automatic int k_scaled(input int frac_bits);
        real scale;
        scale = 1.0;
        for (int j = 0; j < frac_bits; j++) scale = scale * 2.0;
        return int'(K_GAIN * scale);
    endfunction

endpackage

// File: rtl/cordic_angle_fold.sv
// Folds a full-circle binary angle into [-pi/2, pi/2]; negate marks a pi shift.
module cordic_angle_fold #(
    parameter int unsigned BIT_WIDTH = 16
) (
    input  logic [BIT_WIDTH-1:0] angle,
    output logic [BIT_WIDTH-1:0] folded,
    output logic                 negate
);

    // Top bits 01 or 10 mean |angle| > pi/2; flipping the MSB subtracts pi.
    always_comb begin
        negate = angle[BIT_WIDTH-1] ^ angle[BIT_WIDTH-2];
        folded = {angle[BIT_WIDTH-1] ^ negate, angle[BIT_WIDTH-2:0]};
    end

endmodule

// File: rtl/cordic_sincos_pipe.sv
// Iterative CORDIC producing cos and sin of a full-circle angle per handshake.
module cordic_sincos_pipe
    import cordic_pkg::*;
#(
    parameter int unsigned BIT_WIDTH  = 16,
    parameter int unsigned ITERATIONS = 14,
    parameter int unsigned GUARD_BITS = 2,
    parameter int unsigned TAG_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_angle,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_cos,
    output logic [BIT_WIDTH-1:0] out_sin,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam int unsigned ZW      = BIT_WIDTH + GUARD_BITS;
    localparam int unsigned XW      = ZW + 1;
    localparam int unsigned IW      = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam int unsigned ONE_OUT = 1 << (BIT_WIDTH - 2);
    localparam int unsigned RND     = (GUARD_BITS > 0) ? (1 << (GUARD_BITS - 1)) : 0;

    localparam logic signed [XW-1:0] X_INIT  = XW'(k_scaled(int'(BIT_WIDTH + GUARD_BITS - 2)));
    localparam logic signed [XW-1:0] SAT_POS = XW'(ONE_OUT);
    localparam logic signed [XW-1:0] SAT_NEG = -SAT_POS;
    localparam logic signed [XW-1:0] RND_X   = XW'(RND);

    logic signed [ZW-1:0] atan_tab [ITERATIONS];

    for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan
        assign atan_tab[g] = ZW'(atan_bam(g, int'(BIT_WIDTH + GUARD_BITS - 1)));
    end

    logic [BIT_WIDTH-1:0] fold_angle;
    logic                 fold_negate;

    cordic_angle_fold #(.BIT_WIDTH(BIT_WIDTH)) u_fold (
        .angle  (in_angle),
        .folded (fold_angle),
        .negate (fold_negate)
    );

    state_t               state, state_nxt;
    logic [IW-1:0]        iter, iter_nxt;
    logic                 rot_done, rot_done_nxt;
    logic                 negate, negate_nxt;
    logic [TAG_WIDTH-1:0] tag, tag_nxt;
    logic signed [XW-1:0] x, x_nxt, y, y_nxt, x_sh, y_sh;
    logic signed [ZW-1:0] z, z_nxt;
    logic                 in_ready_nxt, out_valid_nxt;
    logic [BIT_WIDTH-1:0] out_cos_nxt, out_sin_nxt;
    logic [TAG_WIDTH-1:0] out_tag_nxt;

    // Drop guard bits (round half up), apply the fold negation, clamp to +/-1.0.
    function automatic logic [BIT_WIDTH-1:0] finalise(input logic signed [XW-1:0] v,
                                                      input logic neg);
        logic signed [XW-1:0] r;
        r = (v + RND_X) >>> GUARD_BITS;
        if (neg) r = -r;
        if (r > SAT_POS)      r = SAT_POS;
        else if (r < SAT_NEG) r = SAT_NEG;
        return BIT_WIDTH'(r);
    endfunction

    always_comb begin
        state_nxt    = state;
        iter_nxt     = iter;
        rot_done_nxt = rot_done;
        negate_nxt   = negate;
        tag_nxt      = tag;
        x_nxt        = x;
        y_nxt        = y;
        z_nxt        = z;
        out_cos_nxt  = out_cos;
        out_sin_nxt  = out_sin;
        out_tag_nxt  = out_tag;
        x_sh         = x >>> iter;
        y_sh         = y >>> iter;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    x_nxt        = X_INIT;
                    y_nxt        = '0;
                    z_nxt        = ZW'($signed(fold_angle)) <<< GUARD_BITS;
                    negate_nxt   = fold_negate;
                    tag_nxt      = in_tag;
                    iter_nxt     = '0;
                    rot_done_nxt = 1'b0;
                    state_nxt    = ROTATE;
                end
            end
            ROTATE: begin
                // Micro-rotations first; one extra cycle then registers the result.
                if (!rot_done) begin
                    if (z[ZW-1]) begin
                        x_nxt = x + y_sh;
                        y_nxt = y - x_sh;
                        z_nxt = z + atan_tab[iter];
                    end else begin
                        x_nxt = x - y_sh;
                        y_nxt = y + x_sh;
                        z_nxt = z - atan_tab[iter];
                    end
                    if (iter == IW'(ITERATIONS - 1)) rot_done_nxt = 1'b1;
                    else                             iter_nxt     = iter + IW'(1);
                end else begin
                    out_cos_nxt = finalise(x, negate);
                    out_sin_nxt = finalise(y, negate);
                    out_tag_nxt = tag;
                    state_nxt   = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        in_ready_nxt  = (state_nxt == IDLE);
        out_valid_nxt = (state_nxt == HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            iter      <= '0;
            rot_done  <= 1'b0;
            negate    <= 1'b0;
            tag       <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_cos   <= '0;
            out_sin   <= '0;
            out_tag   <= '0;
        end else begin
            state     <= state_nxt;
            iter      <= iter_nxt;
            rot_done  <= rot_done_nxt;
            negate    <= negate_nxt;
            tag       <= tag_nxt;
            x         <= x_nxt;
            y         <= y_nxt;
            z         <= z_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            out_cos   <= out_cos_nxt;
            out_sin   <= out_sin_nxt;
            out_tag   <= out_tag_nxt;
        end
    end

endmodule
